// File: rtl/memory_arbiter.sv
// Arbitrates a single-port synchronous RAM between the CPU and an external program loader.
// The loader gets the RAM only after the CPU has parked through the halt_req/halt_ack handshake.
module memory_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned HALT_TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  output logic [DATA_WIDTH-1:0] ldr_rdata,
  output logic                  ldr_ack,
  output logic                  ldr_err,
  output logic                  halt_req,
  input  logic                  halt_ack,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  owner
);

  localparam int unsigned CNT_W = $clog2(HALT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    CPU_OWN   = 3'd0,
    HALT_WAIT = 3'd1,
    ABORT     = 3'd2,
    LDR_OWN   = 3'd3,
    RELEASE   = 3'd4
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               cpu_grant;
  logic               cpu_acc;
  logic               ldr_acc;

  // Accept decode and RAM port steering; owner stays 1 through RELEASE so the bus is stable.
  always_comb begin
    cpu_grant = (state == CPU_OWN) || (state == HALT_WAIT) || (state == ABORT);
    cpu_acc   = cpu_req && cpu_grant;
    ldr_acc   = ldr_req && (state == LDR_OWN);
    mem_we    = (cpu_acc && cpu_we) || (ldr_acc && ldr_we);
    mem_addr  = owner ? ldr_addr  : cpu_addr;
    mem_wdata = owner ? ldr_wdata : cpu_wdata;
  end

  // RAM read data lands in the ack cycle, so it is steered straight through.
  assign cpu_rdata = cpu_ack ? mem_rdata : '0;
  assign ldr_rdata = ldr_ack ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= CPU_OWN;
      cnt      <= '0;
      owner    <= 1'b0;
      halt_req <= 1'b0;
      cpu_ack  <= 1'b0;
      ldr_ack  <= 1'b0;
      ldr_err  <= 1'b0;
    end else begin
      cpu_ack <= cpu_acc;
      ldr_ack <= ldr_acc;
      ldr_err <= 1'b0;
      unique case (state)
        CPU_OWN: begin
          if (ldr_req) begin
            state    <= HALT_WAIT;
            halt_req <= 1'b1;
            cnt      <= '0;
          end
        end
        HALT_WAIT: begin
          if (!ldr_req) begin
            state    <= CPU_OWN;
            halt_req <= 1'b0;
          end else if (halt_ack && !cpu_acc) begin
            state <= LDR_OWN;
            owner <= 1'b1;
          end else if (cnt == CNT_W'(HALT_TIMEOUT - 1)) begin
            state    <= ABORT;
            halt_req <= 1'b0;
            ldr_err  <= 1'b1;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // Loader must drop its request before it may try again.
        ABORT: begin
          if (!ldr_req) state <= CPU_OWN;
        end
        LDR_OWN: begin
          if (!ldr_req) state <= RELEASE;
        end
        RELEASE: begin
          state    <= CPU_OWN;
          owner    <= 1'b0;
          halt_req <= 1'b0;
        end
        default: state <= CPU_OWN;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: behavioural RAM, shadow memory and ack scoreboards.
module tb_memory_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 32;

  typedef struct {
    logic        wr;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_ack;
  logic          ldr_req, ldr_we;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata, ldr_rdata;
  logic          ldr_ack, ldr_err;
  logic          halt_req, halt_ack;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          owner;

  logic [DW-1:0] ram     [256];
  logic [DW-1:0] ref_mem [256];
  exp_t          cpu_q[$];
  exp_t          ldr_q[$];
  int unsigned   cyc;
  int unsigned   errors;
  int unsigned   checks;

  memory_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .HALT_TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ack  (cpu_ack),
    .ldr_req  (ldr_req),
    .ldr_we   (ldr_we),
    .ldr_addr (ldr_addr),
    .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata),
    .ldr_ack  (ldr_ack),
    .ldr_err  (ldr_err),
    .halt_req (halt_req),
    .halt_ack (halt_ack),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .owner    (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous single-port RAM, read data one cycle after the address.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboards: each ack must arrive in its expected cycle with the expected read data.
  always @(negedge clk) begin
    exp_t e;
    if (cpu_ack) begin
      if (cpu_q.size() == 0) check("cpu_unexpected_ack", 1, 0);
      else begin
        e = cpu_q.pop_front();
        check("cpu_ack_cycle", cyc, e.cyc);
        if (!e.wr) check("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
      end
    end else if (cpu_q.size() != 0 && cyc > cpu_q[0].cyc) begin
      check("cpu_missing_ack", 0, 1);
      void'(cpu_q.pop_front());
    end
    if (ldr_ack) begin
      if (ldr_q.size() == 0) check("ldr_unexpected_ack", 1, 0);
      else begin
        e = ldr_q.pop_front();
        check("ldr_ack_cycle", cyc, e.cyc);
        if (!e.wr) check("ldr_rdata", 32'(ldr_rdata), 32'(e.data));
      end
    end else if (ldr_q.size() != 0 && cyc > ldr_q[0].cyc) begin
      check("ldr_missing_ack", 0, 1);
      void'(ldr_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_op(input logic we, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    e.wr = we; e.data = ref_mem[a]; e.cyc = cyc + 1;
    if (we) ref_mem[a] = d;
    cpu_q.push_back(e);
    step();
  endtask

  task automatic ldr_op(input logic we, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    ldr_req = 1'b1; ldr_we = we; ldr_addr = a; ldr_wdata = d;
    e.wr = we; e.data = ref_mem[a]; e.cyc = cyc + 1;
    if (we) ref_mem[a] = d;
    ldr_q.push_back(e);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    logic        got;
    errors = 0; checks = 0;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'((i * 37 + 11) & 255);
      ref_mem[i] = 8'((i * 37 + 11) & 255);
    end
    ram[5] = 8'hA3; ref_mem[5] = 8'hA3;
    rst = 1'b0; halt_ack = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    repeat (3) step();

    check("rst_owner", owner, 0);
    check("rst_halt_req", halt_req, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_ldr_ack", ldr_ack, 0);
    check("rst_ldr_err", ldr_err, 0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 0);
    check("rst_ldr_rdata", 32'(ldr_rdata), 0);
    rst = 1'b1;
    step();

    // Single CPU read
    cpu_op(1'b0, 8'h05, 8'h00);
    cpu_req = 1'b0;
    step(); step();

    // Back-to-back CPU writes then readback
    for (int i = 0; i < 4; i++) cpu_op(1'b1, 8'(8'h10 + i), 8'(8'h40 + 3 * i));
    for (int i = 0; i < 4; i++) cpu_op(1'b0, 8'(8'h10 + i), 8'h00);
    cpu_req = 1'b0;
    step(); step();

    // Loader takeover after a 3-cycle halt handshake
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h20; ldr_wdata = 8'h7E;
    step();
    check("halt_req_set", halt_req, 1);
    check("owner_halt_wait", owner, 0);
    step(); step();
    halt_ack = 1'b1;
    step();
    check("owner_grant", owner, 1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
    ldr_op(1'b1, 8'h20, 8'h7E);
    halt_ack = 1'b0;
    ldr_op(1'b0, 8'h20, 8'h00);
    ldr_op(1'b0, 8'h05, 8'h00);
    ldr_req = 1'b0;
    check("owner_ldr_after_halt_ack_drop", owner, 1);
    step();
    check("owner_in_release", owner, 1);
    check("halt_req_in_release", halt_req, 1);
    step();
    check("owner_released", owner, 0);
    check("halt_req_released", halt_req, 0);
    cpu_op(1'b0, 8'h05, 8'h00);
    cpu_req = 1'b0;
    step(); step();

    // Halt handshake timeout, no retry until the request is dropped
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 8'h20;
    step();
    check("halt_req_timeout_start", halt_req, 1);
    n = 0; got = 1'b0;
    for (int i = 0; i < int'(TO) + 8 && !got; i++) begin
      step();
      n++;
      if (ldr_err) got = 1'b1;
    end
    check("ldr_err_seen", got, 1);
    check("timeout_cycles", n, TO);
    check("halt_req_abort", halt_req, 0);
    halt_ack = 1'b1;
    step();
    check("ldr_err_pulse", ldr_err, 0);
    repeat (3) step();
    check("abort_no_grant", owner, 0);
    check("abort_no_halt_req", halt_req, 0);
    ldr_req = 1'b0; halt_ack = 1'b0;
    step(); step();
    ldr_req = 1'b1;
    step();
    check("halt_req_retry", halt_req, 1);
    halt_ack = 1'b1;
    step();
    check("owner_regrant", owner, 1);

    // Asynchronous reset in the middle of a loader burst
    ldr_op(1'b0, 8'h20, 8'h00);
    check("ldr_ack_pre_rst", ldr_ack, 1);
    #1 rst = 1'b0;
    #1;
    check("arst_owner", owner, 0);
    check("arst_halt_req", halt_req, 0);
    check("arst_ldr_ack", ldr_ack, 0);
    check("arst_cpu_ack", cpu_ack, 0);
    check("arst_ldr_rdata", 32'(ldr_rdata), 0);
    ldr_q.delete();
    ldr_req = 1'b0; halt_ack = 1'b0;
    step();
    rst = 1'b1;
    step();
    cpu_op(1'b0, 8'h20, 8'h00);
    cpu_req = 1'b0;
    step(); step(); step();

    check("cpu_q_drained", cpu_q.size(), 0);
    check("ldr_q_drained", ldr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
